// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one 128-bit memory port between the I-cache and D-cache.
// Round-robin grant, with a lock that keeps a write-back and its refill together.
module mem_bus_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    // Requester identity encoding for r_last / r_lockId: 0 = I-cache, 1 = D-cache.
    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;

    state_t r_state;
    logic   r_last;
    logic   r_wbLock;
    logic   r_lockId;

    state_t w_nextState;
    logic   w_nextLast;
    logic   w_nextWbLock;
    logic   w_nextLockId;
    logic   w_reqI;
    logic   w_reqD;
    logic   w_lockedReq;

    assign w_reqI      = i_mem_read | i_mem_write;
    assign w_reqD      = d_mem_read | d_mem_write;
    assign w_lockedReq = (r_lockId == ID_D) ? w_reqD : w_reqI;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state  <= IDLE;
            r_last   <= ID_I;
            r_wbLock <= 1'b0;
            r_lockId <= ID_I;
        end else begin
            r_state  <= w_nextState;
            r_last   <= w_nextLast;
            r_wbLock <= w_nextWbLock;
            r_lockId <= w_nextLockId;
        end
    end

    // Any IDLE cycle consumes the lock; an honoured lock overrides round-robin.
    always_comb begin
        w_nextState  = r_state;
        w_nextLast   = r_last;
        w_nextWbLock = r_wbLock;
        w_nextLockId = r_lockId;
        case (r_state)
            IDLE: begin
                w_nextWbLock = 1'b0;
                if (r_wbLock && w_lockedReq) begin
                    w_nextState = (r_lockId == ID_D) ? GNT_D : GNT_I;
                end else if (w_reqI && w_reqD) begin
                    w_nextState = (r_last == ID_I) ? GNT_D : GNT_I;
                end else if (w_reqD) begin
                    w_nextState = GNT_D;
                end else if (w_reqI) begin
                    w_nextState = GNT_I;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    w_nextState  = IDLE;
                    w_nextLast   = ID_I;
                    w_nextWbLock = mem_write;
                    w_nextLockId = ID_I;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    w_nextState  = IDLE;
                    w_nextLast   = ID_D;
                    w_nextWbLock = mem_write;
                    w_nextLockId = ID_D;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Memory port and cache returns follow the granted cache; write beats read.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_mem_ready = 1'b0;
        i_mem_rdata = '0;
        d_mem_ready = 1'b0;
        d_mem_rdata = '0;
        case (r_state)
            GNT_I: begin
                mem_write   = i_mem_write;
                mem_read    = i_mem_read & ~i_mem_write;
                mem_addr    = i_mem_addr;
                mem_wdata   = i_mem_wdata;
                i_mem_ready = mem_ready;
                i_mem_rdata = mem_rdata;
            end
            GNT_D: begin
                mem_write   = d_mem_write;
                mem_read    = d_mem_read & ~d_mem_write;
                mem_addr    = d_mem_addr;
                mem_wdata   = d_mem_wdata;
                d_mem_ready = mem_ready;
                d_mem_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    assign owner = r_state;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 128-bit off-chip memory port between the instruction cache and the data cache.
- Each cache drives its usual mem_read/mem_write/mem_addr/mem_wdata and waits for mem_ready. The arbiter grants one cache at a time and forwards that cache's request to memory. It routes mem_ready back only to the granted cache.
- Round-robin fairness, plus a write-back→refill lock so a dirty-miss sequence is not split by the other cache.

Parameters:
- ADDR_W, 28, block address width (word address >> 2).
- DATA_W, 128, block data width.

Ports:
- clk  in  1  system clock, rising edge.
- proc_reset  in  1  reset, asynchronous, active-high.
- i_mem_read  in  1  I-cache read request.
- i_mem_write  in  1  I-cache write request (normally 0; still arbitrated).
- i_mem_addr  in  ADDR_W  I-cache block address.
- i_mem_wdata  in  DATA_W  I-cache write data.
- i_mem_rdata  out  DATA_W  read data to I-cache.
- i_mem_ready  out  1  completion to I-cache.
- d_mem_read  in  1  D-cache read request.
- d_mem_write  in  1  D-cache write request.
- d_mem_addr  in  ADDR_W  D-cache block address.
- d_mem_wdata  in  DATA_W  D-cache write data.
- d_mem_rdata  out  DATA_W  read data to D-cache.
- d_mem_ready  out  1  completion to D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory block address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion, one-cycle pulse.
- owner  out  2  2'b00 idle, 2'b01 I granted, 2'b10 D granted.

Behaviour:
- Request definitions:
  - req_x = x_mem_read | x_mem_write.
  - If a requester asserts both read and write, write wins. It is forwarded as mem_write=1, mem_read=0.
- States: IDLE, GNT_I, GNT_D. These are registered; owner encodes the state directly.
- Registered state also includes:
  - last (1 bit): the most recent grantee.
  - wb_lock (1 bit): set when the completed transaction was a write.
  - lock_id (1 bit): the grantee of that write.
- Reset (async, any time, including mid-transaction):
  - State = IDLE, last = I (so D wins the first tie), wb_lock = 0.
  - All outputs 0: mem_read, mem_write, mem_addr, mem_wdata, i/d_mem_ready, i/d_mem_rdata, owner.
  - An in-flight memory transaction is abandoned. The memory must also be reset.
- IDLE transitions:
  - If wb_lock=1 and the locked cache has req=1: grant that cache. Clear wb_lock.
  - If wb_lock=1 and the locked cache has req=0: clear wb_lock, then apply the normal rules below in the same cycle.
  - Only one req: grant it.
  - Both req: grant the cache that is not last.
  - No req: stay in IDLE.
  - The grant takes effect on the next clock edge.
- In GNT_x:
  - mem_read, mem_write, mem_addr and mem_wdata are combinationally driven from cache x's inputs. They are gated by the state, so in IDLE all are 0 and addr/wdata are 0.
  - The non-granted cache's requests are held off. Its ready stays 0.
- Completion:
  - In GNT_x, mem_ready=1 drives x_mem_ready=1 combinationally in the same cycle.
  - x_mem_rdata = mem_rdata while in GNT_x; otherwise 0.
  - On that clock edge: state→IDLE, last←x, wb_lock←mem_write, lock_id←x.
- Latency:
  - Request first visible in IDLE at cycle N → memory strobe asserted in cycle N+1.
  - One IDLE cycle is required between transactions. In that cycle the cache drops its stale registered request, so it is never re-issued.
- mem_ready while IDLE is ignored. No ready is forwarded and there is no state change.
- A requester that drops req while granted (illegal): the grant is held until mem_ready.
- There is no timeout.

Test Plan:
- Single I read:
  - Stimulus: i_mem_read=1, i_mem_addr=28'h0000010; mem pulses ready 4 cycles after the strobe with rdata=128'hA5...A5.
  - Response: mem_read=1 in cycle N+1; i_mem_ready=1 for one cycle with i_mem_rdata=A5..A5; d_mem_ready stays 0; owner 01→00.
- Simultaneous requests after reset:
  - Stimulus: i_mem_read and d_mem_read both asserted in the same cycle.
  - Response: D is granted first (owner=10, mem_addr=d_mem_addr); after D's ready and one IDLE cycle, I is granted (owner=01).
- Dirty-miss lock:
  - Stimulus: D writes addr 28'h0000123, data 128'h1; I is requesting throughout; D asserts read of 28'h0000456 right after the write's ready.
  - Response: D's read is granted next (owner=10, mem_read=1, addr 456) before I is served.
- Round-robin under load:
  - Stimulus: both caches request continuously for 6 transactions.
  - Response: grants alternate D, I, D, I, D, I.
- Spurious ready and both strobes:
  - Stimulus: mem_ready pulse while IDLE; then D asserts read and write together.
  - Response: no x_mem_ready and owner stays 00 for the spurious pulse; for the second request, mem_write=1 and mem_read=0.
- Reset mid-transaction:
  - Stimulus: assert proc_reset during GNT_I before mem_ready.
  - Response: all outputs 0 and owner=00 immediately (asynchronous); after release, a simultaneous request grants D first.
